aes_inv_mix_columns_serial: RTL and testbench

AES_INV_MIX_COLUMNS_SERIAL -- requirements
Module: aes_inv_mix_columns_serial

---
 rtl/aes_inv_mix_columns_serial.sv | 97 +++++++++
 tb/tb_aes_inv_mix_columns_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_mix_columns_serial.sv
// aes_inv_mix_columns_serial: InvMixColumns over one AES state, ColsPerCycle columns per cycle.
module aes_inv_mix_columns_serial #(
   parameter int ColsPerCycle = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [3:0][3:0][7:0] state_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [3:0][3:0][7:0] state_o,
   output logic                 err_o
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] STEP = 2'(ColsPerCycle);
   localparam logic [1:0] LAST = 2'(4 - ColsPerCycle);
   if (ColsPerCycle != 1 && ColsPerCycle != 2 && ColsPerCycle != 4) begin : g_bad_cols
      $error("ColsPerCycle must be 1, 2 or 4");
   end
   logic [1:0]             state_q, state_d, cnt_q, cnt_d, col;
   logic [3:0][3:0][7:0]   in_q, in_d, res_q, res_d;
   logic [3:0][7:0]        col_in, col_out;
   logic                   err_q, illegal;
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1, built from one xtime chain per byte
   function automatic logic [3:0][7:0] inv_col(input logic [3:0][7:0] a);
      logic [3:0][7:0] x2, x4, x8, o;
      for (int r = 0; r < 4; r++) begin
         x2[r] = xt(a[r]);
         x4[r] = xt(x2[r]);
         x8[r] = xt(x4[r]);
      end
      for (int r = 0; r < 4; r++)
         o[r] = (x8[r] ^ x4[r] ^ x2[r])
              ^ (x8[2'(r + 1)] ^ x2[2'(r + 1)] ^ a[2'(r + 1)])
              ^ (x8[2'(r + 2)] ^ x4[2'(r + 2)] ^ a[2'(r + 2)])
              ^ (x8[2'(r + 3)] ^ a[2'(r + 3)]);
      return o;
   endfunction
   assign illegal     = state_q == 2'd3;
   assign in_ready_o  = state_q == IDLE;
   assign out_valid_o = state_q == DONE;
   assign state_o     = res_q;
   assign err_o       = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      in_d    = in_q;
      res_d   = res_q;
      col     = '0;
      col_in  = '0;
      col_out = '0;
      if (state_q == IDLE && in_valid_i) begin
         state_d = BUSY;
         in_d    = state_i;
         cnt_d   = '0;
      end
      if (state_q == BUSY) begin
         for (int k = 0; k < ColsPerCycle; k++) begin
            col = cnt_q + 2'(k);
            for (int r = 0; r < 4; r++) col_in[r] = in_q[r][col];
            col_out = inv_col(col_in);
            for (int r = 0; r < 4; r++) res_d[r][col] = col_out[r];
         end
         cnt_d   = cnt_q + STEP;
         state_d = (cnt_q == LAST) ? DONE : BUSY;
      end
      if (state_q == DONE && out_ready_i) state_d = IDLE;
      if (clear_i || illegal) begin
         state_d = IDLE;
         cnt_d   = '0;
         in_d    = '0;
         res_d   = '0;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         in_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         in_q    <= in_d;
         res_q   <= res_d;
         err_q   <= err_q | illegal;
      end
   end
endmodule

// File: tb/tb_aes_inv_mix_columns_serial.sv
// tb_aes_inv_mix_columns_serial: directed scoreboard bench for InvMixColumns at 1, 2 and 4 columns per cycle.
module tb_aes_inv_mix_columns_serial;
   typedef logic [3:0][3:0][7:0] st_t;
   logic clk_i = 1'b0;
   logic rst_i, clear_i, in_valid_i, out_ready_i;
   st_t  state_i;
   logic in_ready1, out_valid1, err1, in_ready2, out_valid2, err2, in_ready4, out_valid4, err4;
   st_t  so1, so2, so4;
   int   checks = 0;
   int   failures = 0;
   st_t  sb[$];
   always #5 clk_i = ~clk_i;
   aes_inv_mix_columns_serial #(.ColsPerCycle(1)) u1 (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready1),
      .state_i(state_i), .out_valid_o(out_valid1), .out_ready_i(out_ready_i), .state_o(so1), .err_o(err1));
   aes_inv_mix_columns_serial #(.ColsPerCycle(2)) u2 (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
      .state_i(state_i), .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .state_o(so2), .err_o(err2));
   aes_inv_mix_columns_serial #(.ColsPerCycle(4)) u4 (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready4),
      .state_i(state_i), .out_valid_o(out_valid4), .out_ready_i(out_ready_i), .state_o(so4), .err_o(err4));
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      end
      return p;
   endfunction
   function automatic st_t ref_imc(input st_t s);
      st_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[r][c] = gmul(8'h0e, s[r][c]) ^ gmul(8'h0b, s[(r + 1) % 4][c])
                    ^ gmul(8'h0d, s[(r + 2) % 4][c]) ^ gmul(8'h09, s[(r + 3) % 4][c]);
      return o;
   endfunction
   function automatic st_t mk(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
      logic [3:0][31:0] w;
      st_t s;
      w = {c3, c2, c1, c0};
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = w[c][31 - 8 * r -: 8];
      return s;
   endfunction
   function automatic st_t rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!(in_ready1 && in_ready2 && in_ready4) && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_ready_timeout"}, in_ready1 && in_ready2 && in_ready4, 1'b1);
   endtask
   task automatic pop_cmp(input string tag, input st_t obs);
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 1'b0, 1'b1);
      else chk({tag, "_sb"}, obs, sb.pop_front());
   endtask
   task automatic run_txn(input string tag, input st_t s, input st_t expv);
      int l1 = 0, l2 = 0, l4 = 0;
      st_t g1 = '0, g2 = '0, g4 = '0;
      wait_ready(tag);
      state_i = s;
      in_valid_i = 1'b1;
      sb.push_back(ref_imc(s));
      step();
      in_valid_i = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (out_valid1 && l1 == 0) begin
            l1 = n;
            g1 = so1;
            chk({tag, "_done_not_ready"}, in_ready1, 1'b0);
            pop_cmp(tag, so1);
         end
         if (out_valid2 && l2 == 0) begin l2 = n; g2 = so2; end
         if (out_valid4 && l4 == 0) begin l4 = n; g4 = so4; end
      end
      chk({tag, "_lat1"}, 128'(l1), 128'd4);
      chk({tag, "_lat2"}, 128'(l2), 128'd2);
      chk({tag, "_lat4"}, 128'(l4), 128'd1);
      chk({tag, "_res1"}, g1, expv);
      chk({tag, "_res2"}, g2, expv);
      chk({tag, "_res4"}, g4, expv);
   endtask
   initial begin
      st_t s, held;
      int seen, n;
      rst_i = 1'b1;
      clear_i = 1'b0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      state_i = '0;
      step();
      step();
      chk("rst_in_ready", in_ready1, 1'b1);
      chk("rst_out_valid", out_valid1, 1'b0);
      chk("rst_state_o", so1, '0);
      chk("rst_err", err1, 1'b0);
      rst_i = 1'b0;
      step();
      // known-answer vectors, then random ones against the model
      run_txn("kat_8e4da1bc", mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc),
              mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345));
      run_txn("kat_mixed", mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8),
              mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c));
      s = rnd();
      run_txn("rand_a", s, ref_imc(s));
      s = 128'hffffffff_ffffffff_ffffffff_ffffffff;
      run_txn("all_ff", s, ref_imc(s));
      // output held under backpressure, input ignored
      out_ready_i = 1'b0;
      wait_ready("hold");
      s = rnd();
      state_i = s;
      in_valid_i = 1'b1;
      sb.push_back(ref_imc(s));
      step();
      in_valid_i = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin step(); n++; end
      chk("hold_reach_done", out_valid1, 1'b1);
      held = so1;
      for (int i = 0; i < 10; i++) begin
         in_valid_i = i[0];
         state_i = rnd();
         step();
         chk("hold_valid", out_valid1, 1'b1);
         chk("hold_data", so1, held);
         chk("hold_not_ready", in_ready1, 1'b0);
      end
      in_valid_i = 1'b0;
      pop_cmp("hold", so1);
      out_ready_i = 1'b1;
      step();
      chk("hold_consumed_valid", out_valid1, 1'b0);
      chk("hold_consumed_ready", in_ready1, 1'b1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin step(); seen |= int'(out_valid1); end
      chk("hold_no_capture", 128'(seen), 128'd0);
      // clear during the second BUSY cycle with in_valid_i high
      wait_ready("clear");
      state_i = rnd();
      in_valid_i = 1'b1;
      step();
      state_i = rnd();
      step();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      in_valid_i = 1'b0;
      chk("clear_ready", in_ready1, 1'b1);
      chk("clear_valid", out_valid1, 1'b0);
      chk("clear_state_o", so1, '0);
      chk("clear_err", err1, 1'b0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin step(); seen |= int'(out_valid1 || so1 != '0); end
      chk("clear_no_output", 128'(seen), 128'd0);
      // asynchronous reset in the middle of BUSY
      wait_ready("arst");
      state_i = rnd();
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      step();
      #2 rst_i = 1'b1;
      #1;
      chk("arst_ready", in_ready1, 1'b1);
      chk("arst_valid", out_valid1, 1'b0);
      chk("arst_state_o", so1, '0);
      step();
      rst_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin step(); seen |= int'(out_valid1); end
      chk("arst_no_output", 128'(seen), 128'd0);
      s = rnd();
      run_txn("b2b_a", s, ref_imc(s));
      s = rnd();
      run_txn("b2b_b", s, ref_imc(s));
      // illegal FSM encoding
      force u1.state_q = 2'b11;
      #1 release u1.state_q;
      step();
      chk("illegal_ready", in_ready1, 1'b1);
      chk("illegal_err", err1, 1'b1);
      chk("illegal_state_o", so1, '0);
      s = rnd();
      run_txn("after_illegal", s, ref_imc(s));
      chk("err_sticky", err1, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      step();
      chk("err_cleared", err1, 1'b0);
      chk("sb_drained", 128'(sb.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
